demux1x8_using_conditional_statement_design: RTL and testbench

Registered 1-to-8 demultiplexer: routes a single-bit data input onto one of eight output lines chosen by a 3-bit select, and drives all other lines low. It sits between a serial control source and eight independent single-bit consumers, giving them a glitch-free, clock-aligned strobe/level. Outputs are registered with one cycle of latency, have a valid flag, and clear on asynchronous reset.

---
 rtl/demux1x8_using_conditional_statement_design_if.sv | 13 +
 rtl/demux1x8_using_conditional_statement_design.sv | 77 +++++++
 tb/tb_demux1x8_using_conditional_statement_design.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/demux1x8_using_conditional_statement_design_if.sv
// Bus bundle for the registered 1-to-8 demultiplexer.
// master: the control source driving en/i/s and observing y/valid.
// slave : the demux itself.
interface demux1x8_using_conditional_statement_design_if;
   logic       en;
   logic       i;
   logic [2:0] s;
   logic [7:0] y;
   logic       valid;

   modport master (output en, i, s, input y, valid);
   modport slave  (input en, i, s, output y, valid);
endinterface

// File: rtl/demux1x8_using_conditional_statement_design.sv
// Registered 1-to-8 demultiplexer.
// One lane cell per output line decodes its own select match and registers
// the routed bit, so every output bit comes straight from a flop.
// Build option: define DEMUX_HOLD_EN to make y keep its last captured value
// on en=0 edges; by default y clears on en=0, giving single-cycle strobes.

// One output line: owns y[LANE_ID].
module demux1x8_lane #(
   parameter logic [2:0] LANE_ID = 3'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       i,
   input  logic [2:0] s,
   output logic       q
);
   logic hit;

   // Line carries the data bit only when the select names this lane.
   assign hit = i & (s == LANE_ID);

   // Capture on enabled edges; idle behaviour depends on the hold option.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= 1'b0;
      else if (en)
         q <= hit;
      else
`ifdef DEMUX_HOLD_EN
         q <= q;
`else
         q <= 1'b0;
`endif
   end
endmodule

module demux1x8_using_conditional_statement_design (
   input  logic                                        clk,
   input  logic                                        rst_n,
   demux1x8_using_conditional_statement_design_if.slave bus
);
   localparam int NUM_LANES = 8;
   localparam int STAGES    = 1;

   logic [NUM_LANES-1:0] y_q;
   logic [STAGES:0]      vld_pipe;

   // Per-line cells; each decodes s against its own index.
   genvar k;
   generate
      for (k = 0; k < NUM_LANES; k++) begin : g_lane
         demux1x8_lane #(.LANE_ID(3'(k))) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bus.en),
            .i     (bus.i),
            .s     (bus.s),
            .q     (y_q[k])
         );
      end
   endgenerate

   // Stage 0 of the valid pipe is the enable being sampled this edge.
   assign vld_pipe[0] = bus.en;

   // Valid follows en by one cycle, independent of the hold option.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vld_pipe[STAGES:1] <= '0;
      else
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
   end

   assign bus.y     = y_q;
   assign bus.valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_demux1x8_using_conditional_statement_design.sv
// Self-checking bench for the registered 1-to-8 demultiplexer.
module tb_demux1x8_using_conditional_statement_design;
`ifdef DEMUX_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   logic [7:0] exp_y;
   logic       exp_v;

   demux1x8_using_conditional_statement_design_if bus_if ();

   demux1x8_using_conditional_statement_design dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: what y should become after one edge with these inputs.
   function automatic logic [7:0] ref_y(input logic en, input logic d,
                                        input logic [2:0] sel, input logic [7:0] prev);
      logic [7:0] one;
      one = 8'd1;
      if (en) return d ? (one << sel) : 8'h00;
      return HOLD ? prev : 8'h00;
   endfunction

   task automatic check_state(input string tag);
      logic [7:0] y;
      y = bus_if.y;
      check({tag, "_y"}, y, exp_y);
      check({tag, "_valid"}, {7'd0, bus_if.valid}, {7'd0, exp_v});
      check({tag, "_onehot0"}, {7'd0, (y == 8'h00) || $onehot(y)}, 8'h01);
   endtask

   // Drive one vector, clock it in, check 1 ns after the edge.
   task automatic step(input logic en, input logic d, input logic [2:0] sel, input string tag);
      bus_if.en = en;
      bus_if.i  = d;
      bus_if.s  = sel;
      @(posedge clk);
      #1;
      exp_y = ref_y(en, d, sel, exp_y);
      exp_v = en;
      check_state(tag);
   endtask

   // Async reset pulse mid-cycle; outputs must clear with no clock.
   task automatic reset_pulse(input string tag);
      rst_n = 1'b0;
      #1;
      exp_y = 8'h00;
      exp_v = 1'b0;
      check_state(tag);
      #1;
      rst_n = 1'b1;
   endtask

   logic [7:0] sweep_i;
   logic [2:0] rv_s [6];
   logic [7:0] rv_y [6];

   initial begin
      rst_n     = 1'b0;
      bus_if.en = 1'b0;
      bus_if.i  = 1'b0;
      bus_if.s  = 3'd0;
      exp_y     = 8'h00;
      exp_v     = 1'b0;

      // Reset held across edges with inputs active.
      bus_if.en = 1'b1;
      bus_if.i  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset_hold");
      rst_n = 1'b1;

      // Reset mid-run with y=04, then first capture after release.
      step(1'b1, 1'b1, 3'd2, "pre_reset");
      check("pre_reset_lit", bus_if.y, 8'h04);
      reset_pulse("reset_mid");
      step(1'b1, 1'b1, 3'd0, "post_reset");
      check("post_reset_lit", bus_if.y, 8'h01);

      // Full sweep: (i,s) = (1,0)(0,1)(1,2)(1,3)(1,4)(1,5)(0,6)(1,7).
      sweep_i = 8'b1011_1101;
      for (int k = 0; k < 8; k++) step(1'b1, sweep_i[k], 3'(k), "sweep");
      check("sweep_last", bus_if.y, 8'h80);

      // Revisit and repeat select codes.
      rv_s = '{3'd0, 3'd4, 3'd6, 3'd3, 3'd6, 3'd1};
      rv_y = '{8'h01, 8'h10, 8'h40, 8'h08, 8'h40, 8'h02};
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b1, rv_s[k], "revisit");
         check("revisit_lit", bus_if.y, rv_y[k]);
      end

      // Zero data on every line.
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b0, 3'(k), "zero");
         check("zero_lit", bus_if.y, 8'h00);
      end

      // Enable low after capturing (1,5).
      step(1'b1, 1'b1, 3'd5, "cap5");
      check("cap5_lit", bus_if.y, 8'h20);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, k[0], 3'(k + 1), "en_low");
         check("en_low_lit", bus_if.y, HOLD ? 8'h20 : 8'h00);
         check("en_low_valid", {7'd0, bus_if.valid}, 8'h00);
      end

      // Random traffic with occasional reset pulses.
      for (int n = 0; n < 1000; n++) begin
         if ($urandom_range(0, 49) == 0) reset_pulse("rand_reset");
         step(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time guard so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
